// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control stage: ALUOp codes, instruction field constants,
// HI/LO write modes, FSM states and the decoder result bundle.
package alu_ctrl_pkg;

  localparam logic [4:0] ALU_AND   = 5'd0;
  localparam logic [4:0] ALU_OR    = 5'd1;
  localparam logic [4:0] ALU_ADD   = 5'd2;
  localparam logic [4:0] ALU_XOR   = 5'd3;
  localparam logic [4:0] ALU_SLL   = 5'd4;
  localparam logic [4:0] ALU_SRL   = 5'd5;
  localparam logic [4:0] ALU_SUB   = 5'd6;
  localparam logic [4:0] ALU_NOR   = 5'd7;
  localparam logic [4:0] ALU_ROTR  = 5'd9;
  localparam logic [4:0] ALU_SRA   = 5'd10;
  localparam logic [4:0] ALU_GTZ   = 5'd11;
  localparam logic [4:0] ALU_SLT   = 5'd12;
  localparam logic [4:0] ALU_SLTU  = 5'd15;
  localparam logic [4:0] ALU_MOV   = 5'd16;
  localparam logic [4:0] ALU_LUI   = 5'd17;
  localparam logic [4:0] ALU_GEZ   = 5'd18;
  localparam logic [4:0] ALU_MULTU = 5'd26;
  localparam logic [4:0] ALU_MFLO  = 5'd27;
  localparam logic [4:0] ALU_MFHI  = 5'd28;
  localparam logic [4:0] ALU_MSUB  = 5'd29;
  localparam logic [4:0] ALU_MADD  = 5'd30;
  localparam logic [4:0] ALU_MUL   = 5'd31;

  localparam logic [5:0] OPC_SPECIAL  = 6'd0;
  localparam logic [5:0] OPC_REGIMM   = 6'd1;
  localparam logic [5:0] OPC_SLTI     = 6'd10;
  localparam logic [5:0] OPC_SLTIU    = 6'd11;
  localparam logic [5:0] OPC_ANDI     = 6'd12;
  localparam logic [5:0] OPC_ORI      = 6'd13;
  localparam logic [5:0] OPC_XORI     = 6'd14;
  localparam logic [5:0] OPC_LUI      = 6'd15;
  localparam logic [5:0] OPC_SPECIAL2 = 6'd28;

  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_SRA   = 6'd3;
  localparam logic [5:0] FN_SLLV  = 6'd4;
  localparam logic [5:0] FN_SRLV  = 6'd6;
  localparam logic [5:0] FN_SRAV  = 6'd7;
  localparam logic [5:0] FN_MOVZ  = 6'd10;
  localparam logic [5:0] FN_MOVN  = 6'd11;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MTHI  = 6'd17;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MTLO  = 6'd19;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_ADDU  = 6'd33;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_XOR   = 6'd38;
  localparam logic [5:0] FN_NOR   = 6'd39;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_SLTU  = 6'd43;
  localparam logic [5:0] FN_MADD  = 6'd0;
  localparam logic [5:0] FN_MUL   = 6'd2;
  localparam logic [5:0] FN_MSUB  = 6'd4;

  localparam logic [1:0] HL_NONE = 2'b00;
  localparam logic [1:0] HL_LOAD = 2'b01;
  localparam logic [1:0] HL_ACC  = 2'b10;
  localparam logic [1:0] HL_SUB  = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [4:0] aluop;
    logic       hilo_we;
    logic [1:0] hilo_mode;
    logic       illegal;
    logic       is_mul;
  } dec_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Purely combinational decode of opcode/funct/selector bits into ALU and HI/LO controls.
// Any encoding not in the table falls through to Illegal with ALUOp=ADD.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       i21_i,
  input  logic       i16_i,
  input  logic       i6_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '{aluop: ALU_ADD, hilo_we: 1'b0, hilo_mode: HL_NONE, illegal: 1'b0, is_mul: 1'b0};
    case (opcode_i)
      OPC_SPECIAL: begin
        case (funct_i)
          FN_OR:             dec_o.aluop = ALU_OR;
          FN_NOR:            dec_o.aluop = ALU_NOR;
          FN_XOR:            dec_o.aluop = ALU_XOR;
          FN_SLL, FN_SLLV:   dec_o.aluop = ALU_SLL;
          FN_SRL:            dec_o.aluop = i21_i ? ALU_ROTR : ALU_SRL;
          FN_SRLV:           dec_o.aluop = i6_i ? ALU_ROTR : ALU_SRL;
          FN_SRA, FN_SRAV:   dec_o.aluop = ALU_SRA;
          FN_SLT:            dec_o.aluop = ALU_SLT;
          FN_SLTU:           dec_o.aluop = ALU_SLTU;
          FN_ADD, FN_ADDU:   dec_o.aluop = ALU_ADD;
          FN_SUB:            dec_o.aluop = ALU_SUB;
          FN_MOVZ, FN_MOVN:  dec_o.aluop = ALU_MOV;
          FN_MFHI:           dec_o.aluop = ALU_MFHI;
          FN_MFLO:           dec_o.aluop = ALU_MFLO;
          // mthi/mtlo pass the operand through the adder and load it into HI/LO
          FN_MTHI, FN_MTLO: begin
            dec_o.aluop     = ALU_ADD;
            dec_o.hilo_we   = 1'b1;
            dec_o.hilo_mode = HL_LOAD;
          end
          FN_MULTU: begin
            dec_o.aluop     = ALU_MULTU;
            dec_o.hilo_we   = 1'b1;
            dec_o.hilo_mode = HL_LOAD;
            dec_o.is_mul    = 1'b1;
          end
          default:           dec_o.illegal = 1'b1;
        endcase
      end
      OPC_SPECIAL2: begin
        case (funct_i)
          FN_MADD: begin
            dec_o.aluop     = ALU_MADD;
            dec_o.hilo_we   = 1'b1;
            dec_o.hilo_mode = HL_ACC;
            dec_o.is_mul    = 1'b1;
          end
          FN_MSUB: begin
            dec_o.aluop     = ALU_MSUB;
            dec_o.hilo_we   = 1'b1;
            dec_o.hilo_mode = HL_SUB;
            dec_o.is_mul    = 1'b1;
          end
          FN_MUL: begin
            dec_o.aluop  = ALU_MUL;
            dec_o.is_mul = 1'b1;
          end
          default: dec_o.illegal = 1'b1;
        endcase
      end
      OPC_REGIMM:  dec_o.aluop = i16_i ? ALU_GEZ : ALU_SLT;
      6'd2, 6'd3, 6'd8, 6'd9, 6'd32, 6'd33, 6'd35, 6'd40, 6'd41, 6'd43:
                   dec_o.aluop = ALU_ADD;
      OPC_ANDI:    dec_o.aluop = ALU_AND;
      OPC_ORI:     dec_o.aluop = ALU_OR;
      OPC_XORI:    dec_o.aluop = ALU_XOR;
      OPC_SLTI:    dec_o.aluop = ALU_SLT;
      OPC_SLTIU:   dec_o.aluop = ALU_SLTU;
      OPC_LUI:     dec_o.aluop = ALU_LUI;
      6'd4, 6'd5:  dec_o.aluop = ALU_SUB;
      6'd6, 6'd7:  dec_o.aluop = ALU_GTZ;
      default:     dec_o.illegal = 1'b1;
    endcase
    if (dec_o.illegal) begin
      dec_o.aluop = ALU_ADD;
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control stage between ID and EX: decoded controls registered behind valid/ready,
// with multiply-class ops held in WAIT for MAC_CYCLES-1 cycles before presenting.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OPW        = 5,
  parameter int MAC_CYCLES = 3
) (
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic           Flush,
  input  logic           In_Valid,
  output logic           In_Ready,
  input  logic [5:0]     Opcode,
  input  logic [5:0]     Funct,
  input  logic           I21,
  input  logic           I16,
  input  logic           I6,
  output logic           Out_Valid,
  input  logic           Out_Ready,
  output logic [OPW-1:0] ALUOp,
  output logic           HiLoWe,
  output logic [1:0]     HiLoMode,
  output logic           Illegal,
  output logic           Busy
);

  localparam int CNT_W = $clog2(MAC_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MAC_CYCLES >= 2) ? (MAC_CYCLES - 2) : 0);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [OPW-1:0]   aluop_q;
  logic             hilo_we_q;
  logic [1:0]       hilo_mode_q;
  logic             illegal_q;
  dec_t             dec;
  logic             go_wait;

  alu_ctrl_decode u_decode (
    .opcode_i (Opcode),
    .funct_i  (Funct),
    .i21_i    (I21),
    .i16_i    (I16),
    .i6_i     (I6),
    .dec_o    (dec)
  );

  // In_Ready never looks at In_Valid, so the handshake has no combinational loop.
  assign In_Ready  = !Flush && ((state_q == ST_EMPTY) || ((state_q == ST_FULL) && Out_Ready));
  assign Out_Valid = (state_q == ST_FULL);
  assign Busy      = (state_q == ST_WAIT);
  assign ALUOp     = aluop_q;
  assign HiLoWe    = hilo_we_q;
  assign HiLoMode  = hilo_mode_q;
  assign Illegal   = illegal_q;
  assign go_wait   = dec.is_mul && (MAC_CYCLES > 1);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_EMPTY;
      cnt_q       <= '0;
      aluop_q     <= '0;
      hilo_we_q   <= 1'b0;
      hilo_mode_q <= HL_NONE;
      illegal_q   <= 1'b0;
    end else if (Flush) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
    end else begin
      // An accept is identical from EMPTY and from FULL-with-consume.
      if (In_Valid && In_Ready) begin
        aluop_q     <= OPW'(dec.aluop);
        hilo_we_q   <= dec.hilo_we;
        hilo_mode_q <= dec.hilo_mode;
        illegal_q   <= dec.illegal;
        state_q     <= go_wait ? ST_WAIT : ST_FULL;
        cnt_q       <= go_wait ? CNT_LOAD : '0;
      end else begin
        case (state_q)
          ST_EMPTY: state_q <= ST_EMPTY;
          ST_WAIT: begin
            if (cnt_q == '0) begin
              state_q <= ST_FULL;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          ST_FULL: begin
            if (Out_Ready) begin
              state_q <= ST_EMPTY;
            end
          end
          default: state_q <= ST_EMPTY;
        endcase
      end
    end
  end

endmodule
